apb_reg_bank: RTL and testbench
===============================

# apb_reg_bank

Parametrised APB slave register bank, the next generation of the team's memory-block peripheral. It adds configurable data width and non-power-of-two depth, byte-lane write strobes, programmable wait states and an error response for out-of-range addresses. It sits behind the APB bridge as a generic scratch/config register file.

## Interface
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8, range 8–1024.
- DEPTH, 24, number of registers; any value ≥ 2, need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), word-address width.
- RESET_VAL, 'h0, value loaded into every register on reset.
- WAIT_CYCLES, 0, wait states inserted before ready; range 0–15.
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  reset: asynchronous, active-high.
- addr  input  ADDR_WIDTH  word address.
- wr  input  1  1 = write, 0 = read.
- wdata  input  DATA_WIDTH  write data.
- strb  input  DATA_WIDTH/8  byte-lane write enables; bit i covers wdata[8i+7:8i].
- sel  input  1  slave select.
- enable  input  1  access-phase indicator.
- ready  output  1  transfer-complete indicator; registered.
- rdata  output  DATA_WIDTH  read data; valid only while ready=1; registered.
- slverr  output  1  error response; valid only while ready=1; registered.

## Operation
- FSM states: IDLE, WAIT, RESP. The state register is a single posedge process.
- IDLE: when sel=1 and enable=0 are sampled, latch addr, wr, wdata and strb.
  - With WAIT_CYCLES=0: go to RESP and execute the access.
  - With WAIT_CYCLES>0: go to WAIT and load cnt=WAIT_CYCLES-1.
- WAIT: if sel=0, abort to IDLE with no access. Otherwise, if cnt=0, go to RESP and execute; else decrement cnt.
- Executing an access (the edge entering RESP) sets ready<=1.
  - Write: update only the lanes whose strb bit is 1. strb=0 is a legal no-op write. rdata<=0.
  - Read: rdata<=mem[addr]. strb is ignored.
- RESP: on the next edge, ready<=0, rdata<=0 and slverr<=0, and the FSM returns to IDLE. The access is already committed, so master behaviour during RESP cannot undo it.
- Out-of-range access (addr ≥ DEPTH): no register changes and rdata=0. slverr behaviour is set in Configuration.
- Back-to-back transfers: a new setup phase in the cycle after RESP is accepted normally. Minimum spacing is 2 cycles per transfer.

## Timing
- Reset values: ready=0, rdata=0, slverr=0, state=IDLE, cnt=0, all registers=RESET_VAL.
- Latency: ready rises at the edge that ends the setup phase plus WAIT_CYCLES edges, and stays high for exactly one cycle.
- A write is visible to a read whose setup phase starts in the cycle after RESP.
- Reset asserted mid-transfer (WAIT or RESP) returns everything to reset values. A pending write is discarded.
- sel=1 with enable=1 sampled in IDLE is a protocol violation: ignore it and stay in IDLE.

## Configuration
- APB_REG_BANK_SLVERR_EN
  - Defined: an out-of-range access asserts slverr=1 together with ready.
  - Undefined: slverr is tied to 0. Out-of-range writes are silently dropped and out-of-range reads return 0.

## Structure
- Package apb_reg_bank_pkg holds:
  - the state enum typedef (IDLE, WAIT, RESP);
  - the WAIT counter width constant (4);
  - a lane-count function, DATA_WIDTH/8.
- Sub-module apb_reg_bank_store holds the storage array.
  - It has DEPTH x DATA_WIDTH storage with per-byte write enable, a registered read port and async reset to RESET_VAL.
  - The top level contains the FSM, wait counter, range check and response registers.

## Test plan
- Reset release, then a read of addr 5 → ready high for 1 cycle; rdata=0x00000000; slverr=0.
- WAIT_CYCLES=0: write addr 3 = 0xDEADBEEF with strb=4'hF, then write addr 3 = 0x11223344 with strb=4'b0101, then read addr 3 → rdata=0xDE22BE44; each transfer completes in 2 cycles.
- WAIT_CYCLES=3: read addr 0 → ready rises exactly 3 cycles later than in the zero-wait case; rdata is stable and correct while ready=1.
- With APB_REG_BANK_SLVERR_EN defined: write addr 30 = 0xFFFFFFFF with DEPTH=24 → slverr=1 with ready; the following reads of addr 0–23 are all unchanged. Without the macro: same stimulus → slverr=0.
- WAIT_CYCLES=4: write addr 7 = 0xA5A5A5A5, assert reset during WAIT → outputs at reset values; a later read of addr 7 returns RESET_VAL.
- WAIT_CYCLES=2: drop sel during WAIT → FSM returns to IDLE with no ready pulse and no register change.

Source files
------------

// File: rtl/apb_reg_bank_pkg.sv
// apb_reg_bank_pkg
// Shared types and constants for the APB register bank.
//   state_t      : access FSM state encoding (IDLE, WAIT, RESP)
//   CNT_WIDTH    : width of the wait-state down-counter
//   lane_count() : number of byte lanes for a given data width
package apb_reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_WIDTH = 4;

    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_reg_bank_store.sv
// apb_reg_bank_store
// DEPTH x DATA_WIDTH register storage with per-byte write enables and a
// registered read port. Every register resets to RESET_VAL.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   addr       : word address (caller guarantees addr < DEPTH when we/re set)
//   we, strb   : write enable and byte-lane enables
//   wdata      : write data
//   re         : read enable; rdata loads mem[addr] when set, else 0
//   rdata      : registered read data
module apb_reg_bank_store
    import apb_reg_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 24,
    parameter int                    ADDR_WIDTH = $clog2(DEPTH),
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [ADDR_WIDTH-1:0]              addr,
    input  logic                               we,
    input  logic                               re,
    input  logic [DATA_WIDTH-1:0]              wdata,
    input  logic [lane_count(DATA_WIDTH)-1:0]  strb,
    output logic [DATA_WIDTH-1:0]              rdata
);

    localparam int LANES = lane_count(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                for (int b = 0; b < LANES; b++) begin
                    if (strb[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            // Read port doubles as the response data register: it is cleared
            // on every cycle that is not an in-range read completion.
            rdata <= re ? mem[addr] : '0;
        end
    end

endmodule

// File: rtl/apb_reg_bank.sv
// apb_reg_bank
// Parametrised APB slave register bank with byte strobes, programmable wait
// states and an optional error response for out-of-range addresses.
// Optional feature macro: APB_REG_BANK_SLVERR_EN (out-of-range -> slverr=1).
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   addr, wr, wdata, strb   : APB transfer fields (word address)
//   sel, enable             : APB select / access-phase indicator
//   ready, rdata, slverr    : registered response, valid while ready=1
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a setup phase (sel=1, enable=0)
// WAIT  | transfer latched, counting down wait states; sel=0 aborts
// RESP  | access committed, ready high for this one cycle
module apb_reg_bank
    import apb_reg_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 24,
    parameter int                    ADDR_WIDTH  = $clog2(DEPTH),
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = 'h0,
    parameter int                    WAIT_CYCLES = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [ADDR_WIDTH-1:0]              addr,
    input  logic                               wr,
    input  logic [DATA_WIDTH-1:0]              wdata,
    input  logic [lane_count(DATA_WIDTH)-1:0]  strb,
    input  logic                               sel,
    input  logic                               enable,
    output logic                               ready,
    output logic [DATA_WIDTH-1:0]              rdata,
    output logic                               slverr
);

    localparam int LANES = lane_count(DATA_WIDTH);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   latch, exec;

    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   wr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [LANES-1:0]       strb_q;

    logic [ADDR_WIDTH-1:0]  acc_addr;
    logic                   acc_wr;
    logic [DATA_WIDTH-1:0]  acc_wdata;
    logic [LANES-1:0]       acc_strb;
    logic                   in_range;
    logic                   ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        exec    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel && !enable) begin
                    latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        exec    = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_WIDTH'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (!sel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = RESP;
                    exec    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (latch) begin
            addr_q  <= addr;
            wr_q    <= wr;
            wdata_q <= wdata;
            strb_q  <= strb;
        end
    end

    // Zero-wait accesses execute on the setup edge itself, before the
    // latched copy exists, so they use the live bus fields.
    always_comb begin
        if (state_q == IDLE) begin
            acc_addr  = addr;
            acc_wr    = wr;
            acc_wdata = wdata;
            acc_strb  = strb;
        end else begin
            acc_addr  = addr_q;
            acc_wr    = wr_q;
            acc_wdata = wdata_q;
            acc_strb  = strb_q;
        end
    end

    assign in_range = ({1'b0, acc_addr} < (ADDR_WIDTH+1)'(DEPTH));

    apb_reg_bank_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_VAL  (RESET_VAL)
    ) u_store (
        .clk   (clk),
        .reset (reset),
        .addr  (acc_addr),
        .we    (exec && acc_wr && in_range),
        .re    (exec && !acc_wr && in_range),
        .wdata (acc_wdata),
        .strb  (acc_strb),
        .rdata (rdata)
    );

    // exec is only ever high on the edge entering RESP, so ready/slverr
    // fall automatically on the edge leaving it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= exec;
        end
    end

    assign ready = ready_q;

`ifdef APB_REG_BANK_SLVERR_EN
    logic slverr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slverr_q <= 1'b0;
        end else begin
            slverr_q <= exec && !in_range;
        end
    end

    assign slverr = slverr_q;
`else
    assign slverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_reg_bank.sv
// tb_apb_reg_bank
// Directed bench for apb_reg_bank. Four instances share the clock with
// WAIT_CYCLES = 0, 3, 4, 2 (index 0..3); each has its own bus and reset.
module tb_apb_reg_bank;

    logic        clk;
    logic        reset  [4];
    logic [4:0]  addr   [4];
    logic        wr     [4];
    logic [31:0] wdata  [4];
    logic [3:0]  strb   [4];
    logic        sel    [4];
    logic        enable [4];
    logic        ready  [4];
    logic [31:0] rdata  [4];
    logic        slverr [4];

    int n_cmp = 0;
    int n_mis = 0;

`ifdef APB_REG_BANK_SLVERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int WC = (g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 4 : 2;
        apb_reg_bank #(
            .WAIT_CYCLES (WC)
        ) u_dut (
            .clk    (clk),
            .reset  (reset[g]),
            .addr   (addr[g]),
            .wr     (wr[g]),
            .wdata  (wdata[g]),
            .strb   (strb[g]),
            .sel    (sel[g]),
            .enable (enable[g]),
            .ready  (ready[g]),
            .rdata  (rdata[g]),
            .slverr (slverr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the bus idle; returns at a negedge with the
    // bus idle again. lat = edges after the setup edge until ready is seen.
    task automatic xfer(input int d, input logic w, input logic [4:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic er, output int lat);
        sel[d] = 1'b1; enable[d] = 1'b0; wr[d] = w; addr[d] = a;
        wdata[d] = wd; strb[d] = st;
        lat = 0;
        @(negedge clk);
        enable[d] = 1'b1;
        while (!ready[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!ready[d]) chk("ready_timeout", 64'(ready[d]), 64'd1);
        rd = rdata[d];
        er = slverr[d];
        @(negedge clk);
        chk("ready_one_cycle", 64'(ready[d]), 64'd0);
        chk("rdata_cleared", 64'(rdata[d]), 64'd0);
        sel[d] = 1'b0; enable[d] = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          pulses;
    logic [31:0] model0 [24];

    initial begin
        for (int i = 0; i < 4; i++) begin
            reset[i] = 1'b1; sel[i] = 1'b0; enable[i] = 1'b0; wr[i] = 1'b0;
            addr[i] = '0; wdata[i] = '0; strb[i] = '0;
        end
        for (int i = 0; i < 24; i++) model0[i] = 32'h0;

        @(negedge clk);
        chk("rst_ready", 64'(ready[0]), 64'd0);
        chk("rst_rdata", 64'(rdata[0]), 64'd0);
        chk("rst_slverr", 64'(slverr[0]), 64'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) reset[i] = 1'b0;
        @(negedge clk);
        chk("post_rst_ready_w3", 64'(ready[1]), 64'd0);

        // reset release, read addr 5
        xfer(0, 1'b0, 5'd5, 32'h0, 4'hF, rd, er, lat);
        chk("rd5_data", 64'(rd), 64'h0);
        chk("rd5_err", 64'(er), 64'd0);
        chk("rd5_lat", 64'(lat), 64'd0);

        // byte strobes, zero wait
        xfer(0, 1'b1, 5'd3, 32'hDEADBEEF, 4'hF, rd, er, lat);
        chk("wr3a_lat", 64'(lat), 64'd0);
        chk("wr3a_err", 64'(er), 64'd0);
        xfer(0, 1'b1, 5'd3, 32'h11223344, 4'b0101, rd, er, lat);
        chk("wr3b_lat", 64'(lat), 64'd0);
        xfer(0, 1'b0, 5'd3, 32'h0, 4'h0, rd, er, lat);
        chk("rd3_data", 64'(rd), 64'hDE22BE44);
        chk("rd3_lat", 64'(lat), 64'd0);
        model0[3] = 32'hDE22BE44;

        // strb=0 write is a no-op
        xfer(0, 1'b1, 5'd3, 32'hFFFFFFFF, 4'h0, rd, er, lat);
        xfer(0, 1'b0, 5'd3, 32'h0, 4'hF, rd, er, lat);
        chk("rd3_nostrb", 64'(rd), 64'hDE22BE44);

        // other lanes on another address
        xfer(0, 1'b1, 5'd23, 32'hCAFE1234, 4'b1010, rd, er, lat);
        model0[23] = 32'hCA001200;
        xfer(0, 1'b0, 5'd23, 32'h0, 4'h0, rd, er, lat);
        chk("rd23_data", 64'(rd), 64'hCA001200);

        // three wait states
        xfer(1, 1'b1, 5'd0, 32'h12345678, 4'hF, rd, er, lat);
        chk("w3_wr_lat", 64'(lat), 64'd3);
        xfer(1, 1'b0, 5'd0, 32'h0, 4'hF, rd, er, lat);
        chk("w3_rd_lat", 64'(lat), 64'd3);
        chk("w3_rd_data", 64'(rd), 64'h12345678);

        // out-of-range write / read
        xfer(0, 1'b1, 5'd30, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        chk("oor_wr_err", 64'(er), 64'(EXP_ERR));
        chk("oor_wr_rdata", 64'(rd), 64'h0);
        xfer(0, 1'b0, 5'd24, 32'h0, 4'hF, rd, er, lat);
        chk("oor_rd_err", 64'(er), 64'(EXP_ERR));
        chk("oor_rd_data", 64'(rd), 64'h0);
        for (int i = 0; i < 24; i++) begin
            xfer(0, 1'b0, 5'(i), 32'h0, 4'hF, rd, er, lat);
            chk($sformatf("scan_%0d", i), 64'(rd), 64'(model0[i]));
        end
        chk("scan_err", 64'(er), 64'd0);

        // reset during WAIT discards the pending write (4 wait states)
        sel[2] = 1'b1; enable[2] = 1'b0; wr[2] = 1'b1; addr[2] = 5'd7;
        wdata[2] = 32'hA5A5A5A5; strb[2] = 4'hF;
        @(negedge clk);
        enable[2] = 1'b1;
        chk("w4_wait_ready", 64'(ready[2]), 64'd0);
        @(negedge clk);
        reset[2] = 1'b1;
        @(negedge clk);
        chk("w4_rst_ready", 64'(ready[2]), 64'd0);
        chk("w4_rst_rdata", 64'(rdata[2]), 64'd0);
        chk("w4_rst_slverr", 64'(slverr[2]), 64'd0);
        sel[2] = 1'b0; enable[2] = 1'b0;
        @(negedge clk);
        reset[2] = 1'b0;
        @(negedge clk);
        xfer(2, 1'b0, 5'd7, 32'h0, 4'hF, rd, er, lat);
        chk("w4_rd7_data", 64'(rd), 64'h0);
        chk("w4_rd7_lat", 64'(lat), 64'd4);

        // sel dropped during WAIT aborts the transfer (2 wait states)
        xfer(3, 1'b1, 5'd1, 32'h0BADF00D, 4'hF, rd, er, lat);
        chk("w2_wr_lat", 64'(lat), 64'd2);
        sel[3] = 1'b1; enable[3] = 1'b0; wr[3] = 1'b1; addr[3] = 5'd1;
        wdata[3] = 32'hCAFEF00D; strb[3] = 4'hF;
        @(negedge clk);
        enable[3] = 1'b1;
        pulses = ready[3] ? 1 : 0;
        @(negedge clk);
        if (ready[3]) pulses++;
        sel[3] = 1'b0; enable[3] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready[3]) pulses++;
        end
        chk("w2_abort_pulses", 64'(pulses), 64'd0);
        xfer(3, 1'b0, 5'd1, 32'h0, 4'hF, rd, er, lat);
        chk("w2_rd1_data", 64'(rd), 64'h0BADF00D);
        chk("w2_rd1_lat", 64'(lat), 64'd2);

        // setup with enable already high is ignored
        sel[0] = 1'b1; enable[0] = 1'b1; wr[0] = 1'b1; addr[0] = 5'd4;
        wdata[0] = 32'h77777777; strb[0] = 4'hF;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ready[0]) pulses++;
        end
        sel[0] = 1'b0; enable[0] = 1'b0;
        chk("viol_pulses", 64'(pulses), 64'd0);
        @(negedge clk);
        xfer(0, 1'b0, 5'd4, 32'h0, 4'hF, rd, er, lat);
        chk("viol_rd4_data", 64'(rd), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
